i2c_target: RTL

I2C target (slave) engine: the responding end of the on-board I2C bus, letting the robbit SoC be addressed by an external I2C controller, for example a debug or tuning host. It decodes START, STOP and repeated START, matches a 7-bit address, and maps bus transfers onto a simple 8-bit register-file port. A transfer is an address byte, then a register-pointer byte, then data bytes, or a read after a repeated START. SDA is open-drain through an output-enable. SCL is input-only; clock stretching is not supported.

---
 rtl/i2c_target.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target engine mapping bus transfers onto an 8-bit register port.
// A transfer is an address byte, a register-pointer byte, then write data bytes,
// or a read after a repeated START. SDA is open-drain via sda_oe_o; SCL is input
// only (no clock stretching).
//
// Parameters:
//   TARGET_ADDR  7-bit bus address answered to
//   FILTER_LEN   consecutive equal samples before a filtered level changes (1..7)
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   scl_i, sda_i        bus pin levels
//   sda_oe_o            1 pulls SDA low
//   reg_addr_o          register pointer
//   reg_wdata_o         write data, valid with reg_we_o
//   reg_we_o            one-cycle write strobe
//   reg_re_o            one-cycle read request for reg_addr_o
//   reg_rdata_i         read data, valid the cycle after reg_re_o
//   busy_o              high from address match until STOP/START/reset
// Configuration macro:
//   I2C_TARGET_AUTOINC_EN  pointer auto-increments after each written byte and
//                          each ACKed read byte (wraps 8'hFF -> 8'h00)

module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    localparam int unsigned FCNT_W = 3;
    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILTER_LEN - 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    // ---------------- input conditioning ----------------
    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic              scl_d1_q, sda_d1_q;
    logic [FCNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

    // Synchronizers, glitch filters and one-cycle-delayed filtered levels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_d1_q   <= scl_f_q;
            sda_d1_q   <= sda_f_q;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (scl_sync_q[1] != scl_f_q) begin
            if (scl_cnt_q == FILT_MAX) scl_f_d = scl_sync_q[1];
            else                       scl_cnt_d = scl_cnt_q + FCNT_W'(1);
        end
        if (sda_sync_q[1] != sda_f_q) begin
            if (sda_cnt_q == FILT_MAX) sda_f_d = sda_sync_q[1];
            else                       sda_cnt_d = sda_cnt_q + FCNT_W'(1);
        end
    end

    // Bus condition flags; START/STOP require SCL stably high across the SDA edge
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_f_q & ~scl_d1_q;
    assign scl_fall  = ~scl_f_q &  scl_d1_q;
    assign start_det =  scl_f_q &  scl_d1_q &  sda_d1_q & ~sda_f_q;
    assign stop_det  =  scl_f_q &  scl_d1_q & ~sda_d1_q &  sda_f_q;

    // ---------------- transfer FSM ----------------
    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       we_pend_q, we_pend_d;
    logic       re_pend_q, re_pend_d;
    logic       cap_q, cap_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic [7:0] ptr_next;

`ifdef I2C_TARGET_AUTOINC_EN
    assign ptr_next = reg_addr_q + 8'd1;
`else
    assign ptr_next = reg_addr_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            we_pend_q   <= 1'b0;
            re_pend_q   <= 1'b0;
            cap_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            we_pend_q   <= we_pend_d;
            re_pend_q   <= re_pend_d;
            cap_q       <= cap_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        we_pend_d   = 1'b0;
        re_pend_d   = 1'b0;
        cap_d       = reg_re_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = we_pend_q;
        reg_re_d    = re_pend_q;

        // Read data is valid the cycle after the request
        if (cap_q) tx_d = reg_rdata_i;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            reg_we_d = 1'b0;
            reg_re_d = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            reg_we_d  = 1'b0;
            reg_re_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q) reg_re_d = 1'b1;
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            sda_oe_d = ~tx_q[7];
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_PTR;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b1;
                        state_d    = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // 8th bit: present data now, strobe next cycle
                        if (bit_cnt_q == 4'd7) begin
                            reg_wdata_d = {shift_q[6:0], sda_f_q};
                            we_pend_d   = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = ptr_next;
                        bit_cnt_d  = '0;
                        state_d    = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    // bit_cnt counts falls; MSB was already driven on entry
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d  = ~tx_q[6];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            reg_addr_d = ptr_next;
                            re_pend_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d  = ~tx_q[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign busy_o      = busy_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;

endmodule
